// File: rtl/axi_bridge_ip_tx_pkg.sv
// Shared types for the AXI bridge TX path: arbiter FSM states and the cl_tx beat.
// Beat fields are sized for the widest supported interface; users take the low slices.
package axi_bridge_ip_tx_pkg;

  localparam int unsigned TX_DATA_W_MAX = 512;
  localparam int unsigned TX_USER_W_MAX = 64;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [TX_DATA_W_MAX-1:0]   data;
    logic [TX_DATA_W_MAX/8-1:0] keep;
    logic [TX_USER_W_MAX-1:0]   user;
    logic                       sop;
    logic                       eop;
  } cl_beat_t;

endpackage

// File: rtl/axi_bridge_ip_tx_rr_pick.sv
// Round-robin selector: first requester after ptr_i (wrapping), as index and one-hot.
module axi_bridge_ip_tx_rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  int unsigned cand;

  // Scan farthest-to-nearest so the closest requester after ptr_i is left standing.
  always_comb begin
    cand      = 0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand = (32'(ptr_i) + k) % N;
      if (req_i[IW'(cand)]) begin
        gnt_idx_o = IW'(cand);
        any_o     = 1'b1;
      end
    end
    gnt_oh_o            = '0;
    gnt_oh_o[gnt_idx_o] = any_o;
  end

endmodule

// File: rtl/axi_bridge_ip_tx_arb.sv
// Packet-atomic round-robin arbiter of N_SRC serializer sources onto one registered
// cl_tx stream. Optional idle watchdog with packet abort: AXI_BRIDGE_IP_TX_ARB_WDOG_EN.
//
//   state     | meaning
//   ST_IDLE   | no packet open; pick a source round-robin each cycle a beat can load
//   ST_LOCKED | packet open on grant_q; only that source is served until its eop
module axi_bridge_ip_tx_arb
  import axi_bridge_ip_tx_pkg::*;
#(
  parameter int unsigned IF_W        = 64,
  parameter int unsigned TUSER_W     = 16,
  parameter int unsigned N_SRC       = 2,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      arb_enable_i,
  input  logic [N_SRC-1:0]          src_valid_i,
  input  logic [N_SRC*IF_W-1:0]     src_data_i,
  input  logic [N_SRC*IF_W/8-1:0]   src_keep_i,
  input  logic [N_SRC*TUSER_W-1:0]  src_user_i,
  input  logic [N_SRC-1:0]          src_sop_i,
  input  logic [N_SRC-1:0]          src_eop_i,
  output logic [N_SRC-1:0]          src_ready_o,
  output logic [IF_W-1:0]           cl_tx_data_o,
  output logic [IF_W/8-1:0]         cl_tx_keep_o,
  output logic [TUSER_W-1:0]        cl_tx_user_o,
  output logic                      cl_tx_valid_o,
  output logic                      cl_tx_sop_o,
  output logic                      cl_tx_eop_o,
  input  logic                      cl_tx_ready_i,
  output logic [$clog2(N_SRC)-1:0]  grant_o,
  output logic                      pkt_done_pulse_o,
  output logic                      ev_wdog_abort_pulse_o
);

  localparam int unsigned IW = $clog2(N_SRC);
  localparam int unsigned KW = IF_W / 8;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  cl_beat_t         beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic             pkt_done_q, pkt_done_d;
  logic             wdog_ev_q, wdog_ev_d;

  logic             load_ok;
  logic             abort;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    sel_idx;
  logic             sel_ok;
  logic             unused_bits;

  // Gated by rst_ni so no source sees an accept while reset is held.
  assign load_ok = (!out_valid_q || cl_tx_ready_i) && rst_ni;

`ifdef AXI_BRIDGE_IP_TX_ARB_WDOG_EN
  localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0]    wdog_q, wdog_d;
  logic [N_SRC-1:0] drop_q, drop_d, drop_act;

  // An aborted source sheds its stale tail until it presents a fresh sop.
  assign drop_act = drop_q & src_valid_i & ~src_sop_i;
  assign req      = src_valid_i & ~drop_act & {N_SRC{arb_enable_i}};
  assign abort    = (state_q == ST_LOCKED) && (wdog_q == CW'(WDOG_CYCLES)) && load_ok;

  always_comb begin
    drop_d = drop_q & ~(src_valid_i & src_sop_i);
    if (abort) drop_d[grant_q] = 1'b1;
    wdog_d = wdog_q;
    if (state_q != ST_LOCKED || abort) begin
      wdog_d = '0;
    end else if (src_valid_i[grant_q]) begin
      if (load_ok) wdog_d = '0;
    end else if (wdog_q != CW'(WDOG_CYCLES)) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
      drop_q <= '0;
    end else begin
      wdog_q <= wdog_d;
      drop_q <= drop_d;
    end
  end
`else
  assign req   = src_valid_i & {N_SRC{arb_enable_i}};
  assign abort = 1'b0;
`endif

  axi_bridge_ip_tx_rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_rr_pick (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    pkt_done_d  = 1'b0;
    wdog_ev_d   = 1'b0;
    src_ready_o = '0;

    if (state_q == ST_IDLE) begin
      sel_idx = pick_idx;
      sel_ok  = pick_any;
    end else begin
      sel_idx = grant_q;
      sel_ok  = src_valid_i[grant_q];
    end

    if (load_ok) begin
      out_valid_d = 1'b0;
      if (abort) begin
        beat_d      = '0;
        beat_d.eop  = 1'b1;
        out_valid_d = 1'b1;
        wdog_ev_d   = 1'b1;
        rr_ptr_d    = grant_q;
        state_d     = ST_IDLE;
      end else if (sel_ok) begin
        src_ready_o[sel_idx]       = 1'b1;
        beat_d                     = '0;
        beat_d.data[IF_W-1:0]      = src_data_i[32'(sel_idx)*IF_W +: IF_W];
        beat_d.keep[KW-1:0]        = src_keep_i[32'(sel_idx)*KW +: KW];
        beat_d.user[TUSER_W-1:0]   = src_user_i[32'(sel_idx)*TUSER_W +: TUSER_W];
        beat_d.sop                 = src_sop_i[sel_idx];
        beat_d.eop                 = src_eop_i[sel_idx];
        out_valid_d                = 1'b1;
        grant_d                    = sel_idx;
        if (src_eop_i[sel_idx]) begin
          rr_ptr_d   = sel_idx;
          pkt_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_LOCKED;
        end
      end
    end

`ifdef AXI_BRIDGE_IP_TX_ARB_WDOG_EN
    src_ready_o = src_ready_o | drop_act;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= IW'(N_SRC - 1);
      grant_q     <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      wdog_ev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      pkt_done_q  <= pkt_done_d;
      wdog_ev_q   <= wdog_ev_d;
    end
  end

  assign cl_tx_data_o          = beat_q.data[IF_W-1:0];
  assign cl_tx_keep_o          = beat_q.keep[KW-1:0];
  assign cl_tx_user_o          = beat_q.user[TUSER_W-1:0];
  assign cl_tx_sop_o           = beat_q.sop;
  assign cl_tx_eop_o           = beat_q.eop;
  assign cl_tx_valid_o         = out_valid_q;
  assign grant_o               = grant_q;
  assign pkt_done_pulse_o      = pkt_done_q;
  assign ev_wdog_abort_pulse_o = wdog_ev_q;

  // Beat register is sized for the widest interface; the slack above IF_W/TUSER_W stays zero.
  assign unused_bits = ^{beat_q.data >> IF_W, beat_q.keep >> KW, beat_q.user >> TUSER_W,
                         pick_oh, WDOG_CYCLES == 0};

endmodule

// File: tb/tb_axi_bridge_ip_tx_arb.sv
// Directed bench for axi_bridge_ip_tx_arb: a 2-source instance (watchdog limit 8) and a
// 4-source instance; the watchdog section follows AXI_BRIDGE_IP_TX_ARB_WDOG_EN.
module tb_axi_bridge_ip_tx_arb;

  localparam int IF_W = 64;
  localparam int TW   = 16;
  localparam int KW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // two-source instance
  logic              en2, rdy2;
  logic [1:0]        v2, sop2, eop2, ordy2;
  logic [2*IF_W-1:0] d2;
  logic [2*KW-1:0]   k2;
  logic [2*TW-1:0]   u2;
  logic [IF_W-1:0]   od2;
  logic [KW-1:0]     ok2;
  logic [TW-1:0]     ou2;
  logic              ov2, osop2, oeop2, done2, ev2;
  logic [0:0]        g2;

  // four-source instance
  logic              en4, rdy4;
  logic [3:0]        v4, sop4, eop4, ordy4;
  logic [4*IF_W-1:0] d4;
  logic [4*KW-1:0]   k4;
  logic [4*TW-1:0]   u4;
  logic [IF_W-1:0]   od4;
  logic [KW-1:0]     ok4;
  logic [TW-1:0]     ou4;
  logic              ov4, osop4, oeop4, done4, ev4;
  logic [1:0]        g4;

  axi_bridge_ip_tx_arb #(.IF_W(IF_W), .TUSER_W(TW), .N_SRC(2), .WDOG_CYCLES(8)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .arb_enable_i(en2),
    .src_valid_i(v2), .src_data_i(d2), .src_keep_i(k2), .src_user_i(u2),
    .src_sop_i(sop2), .src_eop_i(eop2), .src_ready_o(ordy2),
    .cl_tx_data_o(od2), .cl_tx_keep_o(ok2), .cl_tx_user_o(ou2), .cl_tx_valid_o(ov2),
    .cl_tx_sop_o(osop2), .cl_tx_eop_o(oeop2), .cl_tx_ready_i(rdy2),
    .grant_o(g2), .pkt_done_pulse_o(done2), .ev_wdog_abort_pulse_o(ev2));

  axi_bridge_ip_tx_arb #(.IF_W(IF_W), .TUSER_W(TW), .N_SRC(4), .WDOG_CYCLES(8)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .arb_enable_i(en4),
    .src_valid_i(v4), .src_data_i(d4), .src_keep_i(k4), .src_user_i(u4),
    .src_sop_i(sop4), .src_eop_i(eop4), .src_ready_o(ordy4),
    .cl_tx_data_o(od4), .cl_tx_keep_o(ok4), .cl_tx_user_o(ou4), .cl_tx_valid_o(ov4),
    .cl_tx_sop_o(osop4), .cl_tx_eop_o(oeop4), .cl_tx_ready_i(rdy4),
    .grant_o(g4), .pkt_done_pulse_o(done4), .ev_wdog_abort_pulse_o(ev4));

  // source model for the two-source instance: beat payload {src, pkt, beat}
  logic [1:0] s_en;
  int s_len [2];
  int s_stall [2];
  int s_beat [2];
  int s_pkt [2];

  function automatic logic [63:0] beat(int s, int p, int b);
    return 64'({8'(s), 8'(p), 8'(b)});
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < 2; i++) begin
      v2[i]                  = s_en[i] && (s_beat[i] != s_stall[i]);
      d2[i*IF_W +: IF_W]     = beat(i, s_pkt[i], s_beat[i]);
      k2[i*KW +: KW]         = '1;
      u2[i*TW +: TW]         = 16'(i*256 + s_beat[i]);
      sop2[i]                = (s_beat[i] == 0);
      eop2[i]                = (s_beat[i] == s_len[i] - 1);
    end
  endtask

  // one clock: note accepts before the edge, advance sources, leave time at edge+1
  task automatic tick();
    logic [1:0] acc;
    #4;
    acc = v2 & ordy2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        if (s_beat[i] == s_len[i] - 1) begin
          s_beat[i] = 0;
          s_pkt[i]++;
        end else begin
          s_beat[i]++;
        end
      end
    end
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en2   = 1'b1;
    rdy2  = 1'b1;
    s_en  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      s_len[i]   = 3;
      s_stall[i] = -1;
      s_beat[i]  = 0;
      s_pkt[i]   = 0;
    end
    drive_src();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    en2 = 1'b1; rdy2 = 1'b1; s_en = 2'b00;
    for (int i = 0; i < 2; i++) begin
      s_len[i] = 3; s_stall[i] = -1; s_beat[i] = 0; s_pkt[i] = 0;
    end
    drive_src();
    en4 = 1'b1; rdy4 = 1'b1; v4 = '1; sop4 = '1; eop4 = '1; k4 = '1; u4 = '0;
    for (int i = 0; i < 4; i++) d4[i*IF_W +: IF_W] = 64'(i + 1);

    // reset values (dut4 sources are valid during reset)
    #12;
    chk("rst_valid", 64'(ov2), 0);
    chk("rst_sop", 64'(osop2), 0);
    chk("rst_eop", 64'(oeop2), 0);
    chk("rst_data", od2, 0);
    chk("rst_keep", 64'(ok2), 0);
    chk("rst_user", 64'(ou2), 0);
    chk("rst_grant", 64'(g2), 0);
    chk("rst_done", 64'(done2), 0);
    chk("rst_ev", 64'(ev2), 0);
    chk("rst_ready4", 64'(ordy4), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single-beat packets on four sources rotate 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr4_valid", 64'(ov4), 1);
      chk("rr4_grant", 64'(g4), 64'(k % 4));
      chk("rr4_data", od4, 64'(k % 4 + 1));
      chk("rr4_done", 64'(done4), 1);
    end
    v4 = '0;

    // two sources, continuous 3-beat packets
    do_reset();
    s_en = 2'b11;
    drive_src();
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("rr2_valid", 64'(ov2), 1);
      chk("rr2_data", od2, beat((k / 3) % 2, (k / 3) / 2, k % 3));
      chk("rr2_done", 64'(done2), 64'(k % 3 == 2));
    end

    // downstream stall mid-packet on source 1
    do_reset();
    s_en = 2'b10; s_len[1] = 4;
    drive_src();
    tick();
    tick();
    chk("stall_pre", od2, beat(1, 0, 1));
    rdy2 = 1'b0;
    #1;
    chk("stall_rdy0", 64'(ordy2), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_data", od2, beat(1, 0, 1));
      chk("stall_valid", 64'(ov2), 1);
      chk("stall_ready", 64'(ordy2), 0);
    end
    rdy2 = 1'b1;
    tick();
    chk("stall_b2", od2, beat(1, 0, 2));
    tick();
    chk("stall_b3", od2, beat(1, 0, 3));
    chk("stall_eop", 64'(oeop2), 1);
    chk("stall_done", 64'(done2), 1);

    // enable dropped inside a packet: packet completes, no new grant
    do_reset();
    s_en = 2'b11; s_len[0] = 4; s_len[1] = 4;
    drive_src();
    tick();
    chk("en_b0", od2, beat(0, 0, 0));
    en2 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("en_beat", od2, beat(0, 0, k));
    end
    chk("en_eop", 64'(oeop2), 1);
    tick();
    chk("en_idle_v", 64'(ov2), 0);
    tick();
    chk("en_idle_v2", 64'(ov2), 0);
    chk("en_idle_rdy", 64'(ordy2), 0);
    en2 = 1'b1;
    tick();
    chk("en_src1", od2, beat(1, 0, 0));
    chk("en_grant", 64'(g2), 1);

    // reset mid-packet
    do_reset();
    s_en = 2'b11;
    drive_src();
    for (int k = 0; k < 4; k++) tick();
    chk("mid_pre", od2, beat(1, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(ov2), 0);
    chk("mid_data", od2, 0);
    chk("mid_sop", 64'(osop2), 0);
    chk("mid_grant", 64'(g2), 0);
    chk("mid_ready", 64'(ordy2), 0);
    chk("mid_done", 64'(done2), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mid_next_g", 64'(g2), 0);
    chk("mid_next_d", od2, beat(0, 1, 0));
    chk("mid_next_done", 64'(done2), 0);

    // source 0 goes silent after two beats of a 4-beat packet
    do_reset();
    s_en = 2'b11; s_len[0] = 4; s_len[1] = 2; s_stall[0] = 2;
    drive_src();
    tick();
    tick();
    chk("wd_b1", od2, beat(0, 0, 1));
`ifdef AXI_BRIDGE_IP_TX_ARB_WDOG_EN
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("wd_wait_v", 64'(ov2), 0);
      chk("wd_wait_ev", 64'(ev2), 0);
    end
    tick();
    chk("wd_close_v", 64'(ov2), 1);
    chk("wd_close_keep", 64'(ok2), 0);
    chk("wd_close_eop", 64'(oeop2), 1);
    chk("wd_close_sop", 64'(osop2), 0);
    chk("wd_close_data", od2, 0);
    chk("wd_ev", 64'(ev2), 1);
    s_stall[0] = -1;
    drive_src();
    #1;
    chk("wd_drop_rdy", 64'(ordy2), 3);
    tick();
    chk("wd_src1_b0", od2, beat(1, 0, 0));
    chk("wd_ev_off", 64'(ev2), 0);
    tick();
    chk("wd_src1_b1", od2, beat(1, 0, 1));
    tick();
    chk("wd_src0_new", od2, beat(0, 1, 0));
    chk("wd_src0_sop", 64'(osop2), 1);
`else
    for (int k = 0; k < 20; k++) tick();
    chk("nowd_valid", 64'(ov2), 0);
    chk("nowd_ev", 64'(ev2), 0);
    chk("nowd_ready", 64'(ordy2), 0);
    chk("nowd_grant", 64'(g2), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
